// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback pipeline definitions used by the decode/issue stages and
// the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REQ_N      = 4;
    localparam int PORT_N     = 2;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 16;
    localparam int STARVE_LIM = 7;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_interface.sv
// Writeback arbiter bundle, clocked by clk, with arbiter-side and bench-side views.
interface regfile_wb_arbiter_interface
    import regfile_wb_arbiter_pkg::*;
(
    input logic clk
);

    logic                          rst;
    logic                          hold;
    logic [REQ_N-1:0]              wb_valid;
    logic [REQ_N-1:0][ADDR_W-1:0]  wb_dest;
    logic [REQ_N-1:0][DATA_W-1:0]  wb_data;
    logic [REQ_N-1:0]              wb_grant;
    logic [PORT_N-1:0]             we;
    logic [PORT_N-1:0][ADDR_W-1:0] waddr;
    logic [PORT_N-1:0][DATA_W-1:0] wdata;

    modport dut (
        input  clk, rst, hold, wb_valid, wb_dest, wb_data,
        output wb_grant, we, waddr, wdata
    );

    modport bench (
        input  clk, wb_grant, we, waddr, wdata,
        output rst, hold, wb_valid, wb_dest, wb_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: first index at or after ptr (wrapping) that is requested
// and not excluded.
module regfile_wb_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N-1:0]     excl,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    // Walk the ring from ptr and latch the first eligible position.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int   pos;
            logic take;
            pos   = (int'(ptr) + k) % N;
            take  = !found && req[pos] && !excl[pos];
            idx   = take ? PTR_W'(pos) : idx;
            found = found | take;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: up to PORT_N same-cycle grants among REQ_N
// requesters, starvation-first then round-robin, registered write ports.
module regfile_wb_arbiter #(
    parameter int REQ_N      = regfile_wb_arbiter_pkg::REQ_N,
    parameter int PORT_N     = regfile_wb_arbiter_pkg::PORT_N,
    parameter int ADDR_W     = regfile_wb_arbiter_pkg::ADDR_W,
    parameter int DATA_W     = regfile_wb_arbiter_pkg::DATA_W,
    parameter int STARVE_LIM = regfile_wb_arbiter_pkg::STARVE_LIM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [REQ_N-1:0]              wb_valid,
    input  logic [REQ_N-1:0][ADDR_W-1:0]  wb_dest,
    input  logic [REQ_N-1:0][DATA_W-1:0]  wb_data,
    output logic [REQ_N-1:0]              wb_grant,
    output logic [PORT_N-1:0]             we,
    output logic [PORT_N-1:0][ADDR_W-1:0] waddr,
    output logic [PORT_N-1:0][DATA_W-1:0] wdata
);
    import regfile_wb_arbiter_pkg::*;

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    wb_req_t [REQ_N-1:0]          req_s;
    logic [REQ_N-1:0]             valid_s;
    logic [REQ_N-1:0]             starved_s;
    logic                         block_s;
    logic [PORT_N-1:0]            port_go_s;
    logic [PORT_N-1:0][PTR_W-1:0] port_sel_s;
    logic [PTR_W-1:0]             rr_nxt_s;
    logic [PTR_W-1:0]             rr_ptr_r;
    logic [REQ_N-1:0][CNT_W-1:0]  wait_cnt_r;

    assign block_s = rst | hold;

    // Bundle requester fields and flag requesters that have waited the limit.
    always_comb begin
        req_s     = '0;
        valid_s   = '0;
        starved_s = '0;
        for (int i = 0; i < REQ_N; i++) begin
            req_s[i]     = '{valid: wb_valid[i], dest: wb_dest[i], data: wb_data[i]};
            valid_s[i]   = req_s[i].valid;
            starved_s[i] = valid_s[i] && (wait_cnt_r[i] == CNT_W'(STARVE_LIM));
        end
    end

    for (genvar p = 0; p < PORT_N; p++) begin : g_port
        logic [REQ_N-1:0] excl_s;
        logic [REQ_N-1:0] cand_s;
        logic [PTR_W-1:0] ptr_s;
        logic [PTR_W-1:0] sel_s;
        logic             use_starved_s;
        logic             found_s;

        if (p == 0) begin : g_head
            assign excl_s = '0;
        end else begin : g_chain
            assign excl_s = g_port[p-1].g_fwd.taken_s;
        end

        // Starved requesters win outright, lowest index first.
        assign use_starved_s = |(starved_s & ~excl_s);
        assign cand_s        = use_starved_s ? starved_s : valid_s;
        assign ptr_s         = use_starved_s ? '0 : rr_ptr_r;

        regfile_wb_arbiter_rr_pick #(
            .N     (REQ_N),
            .PTR_W (PTR_W)
        ) u_rr_pick (
            .req   (cand_s),
            .ptr   (ptr_s),
            .excl  (excl_s),
            .idx   (sel_s),
            .found (found_s)
        );

        if (p < PORT_N - 1) begin : g_fwd
            logic [REQ_N-1:0] taken_s;
            // Later ports skip this pick and anything aimed at the same register.
            always_comb begin
                taken_s = excl_s;
                for (int i = 0; i < REQ_N; i++) begin
                    taken_s[i] = excl_s[i] | (found_s && (req_s[i].dest == req_s[sel_s].dest));
                end
            end
        end

        assign port_go_s[p]  = found_s & ~block_s;
        assign port_sel_s[p] = sel_s;
    end

    // Merge port picks into the grant mask; pointer follows the last port that granted.
    always_comb begin
        wb_grant = '0;
        rr_nxt_s = rr_ptr_r;
        for (int p = 0; p < PORT_N; p++) begin
            wb_grant = wb_grant | (port_go_s[p] ? ({{(REQ_N-1){1'b0}}, 1'b1} << port_sel_s[p]) : '0);
            rr_nxt_s = !port_go_s[p] ? rr_nxt_s :
                       (int'(port_sel_s[p]) == REQ_N - 1) ? '0 : (port_sel_s[p] + PTR_W'(1));
        end
    end

    // Write ports, round-robin pointer and saturating wait counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            we         <= '0;
            waddr      <= '0;
            wdata      <= '0;
            rr_ptr_r   <= '0;
            wait_cnt_r <= '0;
        end else begin
            rr_ptr_r <= rr_nxt_s;
            for (int p = 0; p < PORT_N; p++) begin
                we[p] <= port_go_s[p];
                if (port_go_s[p]) begin
                    waddr[p] <= req_s[port_sel_s[p]].dest;
                    wdata[p] <= req_s[port_sel_s[p]].data;
                end
            end
            for (int i = 0; i < REQ_N; i++) begin
                if (!valid_s[i] || wb_grant[i]) begin
                    wait_cnt_r[i] <= '0;
                end else if (wait_cnt_r[i] != CNT_W'(STARVE_LIM)) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-derived grants checked in-cycle,
// expected write-port values queued and compared one cycle later.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [1:0]       we;
        logic [1:0][3:0]  addr;
        logic [1:0][15:0] data;
    } exp_t;

    logic             clk = 1'b0;
    int               n_assert = 0;
    int               n_fail   = 0;
    exp_t             sb_q[$];
    logic [1:0][3:0]  last_addr = '0;
    logic [1:0][15:0] last_data = '0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_interface bus (.clk(clk));

    regfile_wb_arbiter dut (
        .clk      (bus.clk),
        .rst      (bus.rst),
        .hold     (bus.hold),
        .wb_valid (bus.wb_valid),
        .wb_dest  (bus.wb_dest),
        .wb_data  (bus.wb_data),
        .wb_grant (bus.wb_grant),
        .we       (bus.we),
        .waddr    (bus.waddr),
        .wdata    (bus.wdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_we,
                        input logic [3:0] a0, input logic [15:0] d0,
                        input logic [3:0] a1, input logic [15:0] d1);
        exp_t e;
        exp_t got;
        #4;
        chk({tag, ".grant"}, 64'(bus.wb_grant), 64'(exp_gnt));
        if (exp_we[0]) begin last_addr[0] = a0; last_data[0] = d0; end
        if (exp_we[1]) begin last_addr[1] = a1; last_data[1] = d1; end
        e.we   = exp_we;
        e.addr = last_addr;
        e.data = last_data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, ".we"},    64'(bus.we),    64'(got.we));
        chk({tag, ".waddr"}, 64'(bus.waddr), 64'(got.addr));
        chk({tag, ".wdata"}, 64'(bus.wdata), 64'(got.data));
    endtask

    initial begin
        // Reset while every requester is valid: nothing may be granted or written.
        bus.rst      = 1'b1;
        bus.hold     = 1'b0;
        bus.wb_valid = 4'b1111;
        bus.wb_dest  = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.wb_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        step("rst_valid", 4'b0000, 2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000);
        chk("rst_rr_ptr", 64'(dut.rr_ptr_r), 64'd0);
        chk("rst_wait_cnt", 64'(dut.wait_cnt_r), 64'd0);

        // Four distinct destinations drain two per cycle.
        bus.rst = 1'b0;
        step("all4_a", 4'b0011, 2'b11, 4'd1, 16'h1111, 4'd2, 16'h2222);
        chk("all4_rr_mid", 64'(dut.rr_ptr_r), 64'd2);
        bus.wb_valid = 4'b1100;
        step("all4_b", 4'b1100, 2'b11, 4'd3, 16'h3333, 4'd4, 16'h4444);
        chk("all4_rr_wrap", 64'(dut.rr_ptr_r), 64'd0);

        // Same destination: second request must wait a cycle.
        bus.wb_valid   = 4'b0011;
        bus.wb_dest[0] = 4'd5;
        bus.wb_dest[1] = 4'd5;
        bus.wb_data[0] = 16'hAAAA;
        bus.wb_data[1] = 16'hBBBB;
        step("samedest_a", 4'b0001, 2'b01, 4'd5, 16'hAAAA, 4'd0, 16'h0000);
        bus.wb_valid = 4'b0010;
        step("samedest_b", 4'b0010, 2'b01, 4'd5, 16'hBBBB, 4'd0, 16'h0000);

        // Hold blocks grants but the wait counter keeps counting.
        bus.wb_valid   = 4'b0001;
        bus.wb_dest[0] = 4'd6;
        bus.wb_data[0] = 16'h6666;
        bus.hold       = 1'b1;
        for (int k = 0; k < 3; k++) step("hold", 4'b0000, 2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000);
        chk("hold_wait_cnt0", 64'(dut.wait_cnt_r[0]), 64'd3);
        bus.hold = 1'b0;
        step("hold_release", 4'b0001, 2'b01, 4'd6, 16'h6666, 4'd0, 16'h0000);
        chk("hold_rr_ptr", 64'(dut.rr_ptr_r), 64'd1);

        // Lone requester 2 to the top register.
        bus.wb_valid   = 4'b0100;
        bus.wb_dest[2] = 4'd15;
        bus.wb_data[2] = 16'hFFFF;
        step("lone_req2", 4'b0100, 2'b01, 4'd15, 16'hFFFF, 4'd0, 16'h0000);
        chk("lone_rr_ptr", 64'(dut.rr_ptr_r), 64'd3);

        // Starved requester 1 beats round-robin (pointer at 3).
        bus.wb_valid   = 4'b0010;
        bus.wb_dest    = {4'd7, 4'd0, 4'd7, 4'd7};
        bus.wb_data    = {16'h7003, 16'h0000, 16'h7001, 16'h7000};
        bus.hold       = 1'b1;
        for (int k = 0; k < 7; k++) step("starve_hold", 4'b0000, 2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000);
        chk("starve_wait_cnt1", 64'(dut.wait_cnt_r[1]), 64'd7);
        bus.hold     = 1'b0;
        bus.wb_valid = 4'b1011;
        step("starve_win", 4'b0010, 2'b01, 4'd7, 16'h7001, 4'd0, 16'h0000);
        bus.wb_valid = 4'b1001;
        step("starve_rr", 4'b1000, 2'b01, 4'd7, 16'h7003, 4'd0, 16'h0000);
        bus.wb_valid = 4'b0001;
        step("starve_last", 4'b0001, 2'b01, 4'd7, 16'h7000, 4'd0, 16'h0000);
        chk("starve_rr_ptr", 64'(dut.rr_ptr_r), 64'd1);

        // Three starved requesters: the two lowest take the ports.
        bus.wb_valid = 4'b1101;
        bus.wb_dest  = {4'd10, 4'd9, 4'd0, 4'd8};
        bus.wb_data  = {16'hA000, 16'h9000, 16'h0000, 16'h8000};
        bus.hold     = 1'b1;
        for (int k = 0; k < 7; k++) step("multi_hold", 4'b0000, 2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000);
        bus.hold = 1'b0;
        step("multi_starve", 4'b0101, 2'b11, 4'd8, 16'h8000, 4'd9, 16'h9000);
        chk("multi_wait_cnt3", 64'(dut.wait_cnt_r[3]), 64'd7);
        chk("multi_rr_ptr", 64'(dut.rr_ptr_r), 64'd3);
        bus.wb_valid = 4'b1000;
        step("multi_tail", 4'b1000, 2'b01, 4'd10, 16'hA000, 4'd0, 16'h0000);

        // Everyone re-requests one register; requester 3 served by the fourth cycle.
        bus.wb_valid = 4'b1111;
        bus.wb_dest  = {4'd11, 4'd11, 4'd11, 4'd11};
        bus.wb_data  = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
        for (int k = 0; k < 4; k++) begin
            step("rotate", 4'b0001 << k, 2'b01, 4'd11, 16'hC000 + 16'(k), 4'd0, 16'h0000);
        end
        chk("rotate_rr_wrap", 64'(dut.rr_ptr_r), 64'd0);

        bus.wb_valid = 4'b0000;
        step("idle", 4'b0000, 2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000);
        chk("idle_wait_cnt", 64'(dut.wait_cnt_r), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
